// File: rtl/dmi_fabric_if.sv
// dmi_fabric_if: upstream DMI request/response plus per-DM request/response bus; slave = fabric side, master = DTM/DM side
interface dmi_fabric_if #(
  parameter int N_DM     = 2,
  parameter int DM_ABITS = 7
);
  localparam int IDXW  = (N_DM > 1) ? $clog2(N_DM) : 1;
  localparam int ABITS = DM_ABITS + IDXW;
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ABITS-1:0]      req_addr_i;
  logic [31:0]           req_data_i;
  logic [1:0]            req_op_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_data_o;
  logic [1:0]            rsp_op_o;
  logic [N_DM-1:0]       dm_req_valid_o;
  logic [N_DM-1:0]       dm_req_ready_i;
  logic [DM_ABITS-1:0]   dm_req_addr_o;
  logic [31:0]           dm_req_data_o;
  logic [1:0]            dm_req_op_o;
  logic [N_DM-1:0]       dm_rsp_valid_i;
  logic [N_DM-1:0]       dm_rsp_ready_o;
  logic [N_DM*32-1:0]    dm_rsp_data_i;
  logic [N_DM*2-1:0]     dm_rsp_op_i;
  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_op_i, rsp_ready_i,
           dm_req_ready_i, dm_rsp_valid_i, dm_rsp_data_i, dm_rsp_op_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_op_o,
           dm_req_valid_o, dm_req_addr_o, dm_req_data_o, dm_req_op_o, dm_rsp_ready_o
  );
  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_op_i, rsp_ready_i,
           dm_req_ready_i, dm_rsp_valid_i, dm_rsp_data_i, dm_rsp_op_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_op_o,
           dm_req_valid_o, dm_req_addr_o, dm_req_data_o, dm_req_op_o, dm_rsp_ready_o
  );
endinterface

// File: rtl/dmi_fabric.sv
// dmi_fabric: routes DMI transactions to N_DM debug modules with per-phase timeout, dead-DM fencing and sticky error; ports clk, rst, bus (dmi_fabric_if.slave), busy_o, dead_o, err_o, clear_i
module dmi_fabric #(
  parameter int N_DM     = 2,
  parameter int DM_ABITS = 7,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  dmi_fabric_if.slave     bus,
  output logic            busy_o,
  output logic [N_DM-1:0] dead_o,
  output logic            err_o,
  input  logic            clear_i
);
  localparam int IDXW  = (N_DM > 1) ? $clog2(N_DM) : 1;
  localparam int ABITS = DM_ABITS + IDXW;
  localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int NX    = 2 ** IDXW;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              r_state, w_next;
  logic [DM_ABITS-1:0] r_addr;
  logic [IDXW-1:0]     r_idx;
  logic [31:0]         r_data, r_rsp_data;
  logic [1:0]          r_op, r_rsp_op;
  logic [CW-1:0]       r_cnt;
  logic [N_DM-1:0]     r_dead;
  logic                r_err;
  logic [IDXW-1:0]     w_req_idx;
  logic [NX-1:0]       w_dead_x, w_rr_x, w_rv_x;
  logic [N_DM-1:0]     w_onehot;
  logic                w_reject, w_nop, w_req_hs, w_rsp_hs, w_to;
  logic [31:0]         w_sel_data;
  logic [1:0]          w_sel_op;
  assign w_req_idx = bus.req_addr_i[ABITS-1:DM_ABITS];
  assign w_dead_x  = NX'(r_dead);
  assign w_rr_x    = NX'(bus.dm_req_ready_i);
  assign w_rv_x    = NX'(bus.dm_rsp_valid_i);
  assign w_onehot  = N_DM'(1) << r_idx;
  assign w_reject  = ({1'b0, w_req_idx} >= (IDXW + 1)'(N_DM)) || w_dead_x[w_req_idx];
  assign w_nop     = bus.req_op_i == 2'd0 || bus.req_op_i == 2'd3;
  assign w_req_hs  = r_state == ISSUE && w_rr_x[r_idx];
  assign w_rsp_hs  = r_state == WAIT && w_rv_x[r_idx];
  // a handshake in the final allowed cycle beats the abort
  assign w_to      = ((r_state == ISSUE && !w_req_hs) || (r_state == WAIT && !w_rsp_hs)) && r_cnt == CW'(TIMEOUT);
  always_comb begin
    w_sel_data = '0;
    w_sel_op   = '0;
    for (int k = 0; k < N_DM; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_sel_data = bus.dm_rsp_data_i[32*k +: 32];
        w_sel_op   = bus.dm_rsp_op_i[2*k +: 2];
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !bus.req_valid_i ? IDLE : (w_reject || w_nop) ? RESP : ISSUE;
      ISSUE:   w_next = w_req_hs ? WAIT : w_to ? RESP : ISSUE;
      WAIT:    w_next = (w_rsp_hs || w_to) ? RESP : WAIT;
      default: w_next = bus.rsp_ready_i ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_op       <= '0;
      r_rsp_data <= '0;
      r_rsp_op   <= '0;
      r_cnt      <= '0;
      r_dead     <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state != w_next) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE && bus.req_valid_i) begin
        r_addr     <= bus.req_addr_i[DM_ABITS-1:0];
        r_idx      <= w_req_idx;
        r_data     <= bus.req_data_i;
        r_op       <= bus.req_op_i;
        r_rsp_data <= '0;
        r_rsp_op   <= w_reject ? 2'd2 : 2'd0;
      end
      if (w_rsp_hs) begin
        r_rsp_data <= w_sel_data;
        r_rsp_op   <= w_sel_op;
      end
      if (w_to) begin
        r_rsp_data <= '0;
        r_rsp_op   <= 2'd2;
      end
      r_dead <= (clear_i ? '0 : r_dead) | (w_to ? w_onehot : '0);
      r_err  <= (!clear_i && r_err) || w_to;
    end
  end
  assign bus.req_ready_o    = r_state == IDLE;
  assign bus.rsp_valid_o    = r_state == RESP;
  assign bus.rsp_data_o     = r_rsp_data;
  assign bus.rsp_op_o       = r_rsp_op;
  assign bus.dm_req_valid_o = (r_state == ISSUE) ? w_onehot : '0;
  assign bus.dm_req_addr_o  = r_addr;
  assign bus.dm_req_data_o  = r_data;
  assign bus.dm_req_op_o    = r_op;
  // every DM except the one being issued to may drain responses; late answers from fenced DMs are dropped
  assign bus.dm_rsp_ready_o = (r_state == ISSUE) ? ~w_onehot : '1;
  assign busy_o             = r_state != IDLE;
  assign dead_o             = r_dead;
  assign err_o              = r_err;
endmodule

// File: tb/tb_dmi_fabric.sv
// tb_dmi_fabric: randomized and directed checks of dmi_fabric against a transaction-level reference model
module tb_dmi_fabric;
  localparam int N  = 3;
  localparam int DA = 7;
  localparam int TO = 4;
  localparam int IW = 2;
  logic         clk = 1'b0;
  logic         rst, clear;
  logic         busy, err;
  logic [N-1:0] dead;
  logic [N-1:0] m_dead;
  logic         m_err;
  int           checks = 0;
  int           errors = 0;
  dmi_fabric_if #(.N_DM(N), .DM_ABITS(DA)) bus ();
  dmi_fabric #(.N_DM(N), .DM_ABITS(DA), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_o(busy), .dead_o(dead), .err_o(err), .clear_i(clear)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_dead = '0;
    m_err  = 1'b0;
    chk("clear_dead", dead, 0);
    chk("clear_err", err, 0);
  endtask
  task automatic txn(input int idx, input logic [6:0] lo, input logic [1:0] op, input logic [31:0] wd,
                     input int d1, input int d2, input logic [31:0] rd, input logic [1:0] rop, input int bp);
    int e_lat, e_vcyc, lat, vcyc, wc;
    logic [31:0] e_data;
    logic [1:0] e_op;
    logic done, pend, hs, bad, leak;
    if (idx >= N || m_dead[idx]) begin
      e_op = 2; e_data = 0; e_lat = 1; e_vcyc = 0;
    end else if (op == 0 || op == 3) begin
      e_op = 0; e_data = 0; e_lat = 1; e_vcyc = 0;
    end else if (d1 > TO) begin
      e_op = 2; e_data = 0; e_lat = TO + 2; e_vcyc = TO + 1;
      m_dead[idx] = 1'b1; m_err = 1'b1;
    end else if (d2 > TO) begin
      e_op = 2; e_data = 0; e_lat = d1 + TO + 3; e_vcyc = d1 + 1;
      m_dead[idx] = 1'b1; m_err = 1'b1;
    end else begin
      e_op = rop; e_data = rd; e_lat = d1 + d2 + 3; e_vcyc = d1 + 1;
    end
    bus.dm_rsp_data_i = {$urandom, $urandom, $urandom};
    bus.dm_rsp_op_i   = 6'($urandom);
    bus.req_addr_i  = {IW'(idx), lo};
    bus.req_data_i  = wd;
    bus.req_op_i    = op;
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    lat = 0; vcyc = 0; wc = 0; done = 0; pend = 0; hs = 0; bad = 0; leak = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      lat++;
      if (bus.rsp_valid_o) done = 1'b1;
      else begin
        if ((bus.dm_req_valid_o & ~(N'(1) << idx)) != 0) leak = 1'b1;
        if (idx < N && bus.dm_req_valid_o[idx]) begin
          vcyc++;
          if (bus.dm_req_addr_o !== lo || bus.dm_req_data_o !== wd || bus.dm_req_op_o !== op) bad = 1'b1;
        end
        if (pend) hs = 1'b1;
        pend = 1'b0;
        bus.dm_req_ready_i = '0;
        bus.dm_rsp_valid_i = '0;
        if (idx < N && bus.dm_req_valid_o[idx] && vcyc - 1 == d1) begin
          bus.dm_req_ready_i[idx] = 1'b1;
          pend = 1'b1;
        end
        if (hs) begin
          if (wc == d2) begin
            bus.dm_rsp_valid_i[idx] = 1'b1;
            bus.dm_rsp_data_i[32*idx +: 32] = rd;
            bus.dm_rsp_op_i[2*idx +: 2] = rop;
          end
          wc++;
        end
        step();
      end
    end
    bus.dm_req_ready_i = '0;
    bus.dm_rsp_valid_i = '0;
    chk("rsp_seen", done, 1);
    chk("latency", lat, e_lat);
    chk("rsp_data", bus.rsp_data_o, e_data);
    chk("rsp_op", bus.rsp_op_o, e_op);
    chk("dm_valid_cycles", vcyc, e_vcyc);
    chk("dm_valid_leak", leak, 0);
    chk("dm_broadcast", bad, 0);
    chk("dead", dead, m_dead);
    chk("err", err, m_err);
    if (bp > 0) begin
      for (int b = 0; b < bp; b++) step();
      chk("bp_valid", bus.rsp_valid_o, 1);
      chk("bp_data", bus.rsp_data_o, e_data);
      chk("bp_op", bus.rsp_op_o, e_op);
      chk("bp_req_ready", bus.req_ready_o, 0);
      chk("bp_busy", busy, 1);
    end
    bus.rsp_ready_i = 1'b1;
    step();
    bus.rsp_ready_i = 1'b0;
    chk("back_idle", bus.req_ready_o, 1);
  endtask
  initial begin
    rst = 1'b1; clear = 1'b0;
    m_dead = '0; m_err = 1'b0;
    bus.req_valid_i = 0; bus.req_addr_i = '0; bus.req_data_i = '0; bus.req_op_i = '0;
    bus.rsp_ready_i = 0; bus.dm_req_ready_i = '0; bus.dm_rsp_valid_i = '0;
    bus.dm_rsp_data_i = '0; bus.dm_rsp_op_i = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_dm_valid", bus.dm_req_valid_o, 0);
    chk("rst_dead", dead, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", bus.rsp_data_o, 0);
    chk("rst_dm_addr", bus.dm_req_addr_o, 0);
    txn(1, 7'h11, 2'd1, 32'h0, 0, 0, 32'hDEADBEEF, 2'd0, 0);
    txn(0, 7'h05, 2'd0, 32'h55, 0, 0, 32'h0, 2'd0, 0);
    txn(2, 7'h06, 2'd3, 32'h66, 0, 0, 32'h0, 2'd0, 0);
    txn(3, 7'h22, 2'd2, 32'hCAFE, 0, 0, 32'h0, 2'd0, 0);
    txn(0, 7'h10, 2'd1, 32'h0, TO + 3, 0, 32'h0, 2'd0, 0);
    txn(0, 7'h10, 2'd1, 32'h0, 0, 0, 32'h77, 2'd0, 0);
    txn(1, 7'h12, 2'd1, 32'h0, 1, 2, 32'h0BADF00D, 2'd3, 0);
    bus.dm_rsp_valid_i[0] = 1'b1;
    bus.dm_rsp_data_i[31:0] = 32'h1234;
    bus.dm_rsp_op_i[1:0] = 2'd0;
    #1;
    chk("stray_ready", bus.dm_rsp_ready_o[0], 1);
    step();
    bus.dm_rsp_valid_i = '0;
    chk("stray_hidden", bus.rsp_valid_o, 0);
    chk("stray_idle", bus.req_ready_o, 1);
    do_clear();
    txn(0, 7'h13, 2'd1, 32'h0, 0, 0, 32'h00C0FFEE, 2'd0, 0);
    txn(2, 7'h14, 2'd2, 32'hABCD, TO, TO, 32'h5A5A, 2'd0, 0);
    txn(2, 7'h15, 2'd1, 32'h0, 0, TO + 1, 32'h5A5A, 2'd0, 0);
    do_clear();
    txn(1, 7'h16, 2'd1, 32'h0, 2, 1, 32'h13579BDF, 2'd0, 10);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      txn($urandom_range(0, 3), 7'($urandom), 2'($urandom), $urandom,
          $urandom_range(0, TO + 2), $urandom_range(0, TO + 2), $urandom, 2'($urandom),
          ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
    end
    do_clear();
    bus.req_addr_i = {IW'(1), 7'h20};
    bus.req_op_i = 2'd1;
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    bus.dm_req_ready_i[1] = 1'b1;
    step();
    bus.dm_req_ready_i = '0;
    chk("wait_busy", busy, 1);
    chk("wait_rsp_ready", bus.dm_rsp_ready_o[1], 1);
    rst = 1'b1;
    #1;
    chk("arst_req_ready", bus.req_ready_o, 1);
    chk("arst_rsp_valid", bus.rsp_valid_o, 0);
    chk("arst_dm_valid", bus.dm_req_valid_o, 0);
    chk("arst_busy", busy, 0);
    step();
    rst = 1'b0;
    m_dead = '0;
    m_err = 1'b0;
    txn(2, 7'h21, 2'd1, 32'h0, 0, 0, 32'h2468ACE0, 2'd0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
